// File: rtl/dstack_pkg.sv
// Shared opcode, movement and error encodings for the dstack sequencer.
package dstack_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0, OP_PUSH = 4'h1, OP_DROP = 4'h2, OP_DUP  = 4'h3,
    OP_SWAP  = 4'h4, OP_OVER = 4'h5, OP_PICK = 4'h6, OP_ROLL = 4'h7,
    OP_ADD   = 4'h8, OP_SUB  = 4'h9, OP_AND  = 4'hA, OP_OR   = 4'hB,
    OP_XOR   = 4'hC, OP_NIP  = 4'hD, OP_DROP2 = 4'hE, OP_DUP2 = 4'hF
  } op_t;

  typedef enum logic {ST_IDLE, ST_EXEC2} seq_state_t;

  localparam logic [1:0] S_NOTHING   = 2'b00;
  localparam logic [1:0] S_PUSH_ONCE = 2'b01;
  localparam logic [1:0] S_POP_ONCE  = 2'b10;
  localparam logic [1:0] S_POP_TWICE = 2'b11;

  localparam logic [1:0] ERR_UNDERFLOW = 2'b01;
  localparam logic [1:0] ERR_OVERFLOW  = 2'b10;

endpackage

// File: rtl/dstack_op_decode.sv
// Combinational opcode decode: dstack control plus depth requirement and growth/shrink.
module dstack_op_decode
  import dstack_pkg::*;
#(
  parameter int RA_W = 6
) (
  input  logic [3:0]      i_op_code,
  input  logic [RA_W-1:0] i_op_n,
  output logic [1:0]      o_movement,
  output logic            o_rotate,
  output logic [RA_W-1:0] o_rot_addr,
  output logic [RA_W:0]   o_need,
  output logic [1:0]      o_inc,
  output logic [1:0]      o_dec,
  output logic            o_multi
);

  logic [RA_W:0] w_need_n;
  assign w_need_n = {1'b0, i_op_n} + (RA_W+1)'(2);

  always_comb begin
    o_movement = S_NOTHING;
    o_rotate   = 1'b0;
    o_rot_addr = '0;
    o_need     = '0;
    o_inc      = 2'd0;
    o_dec      = 2'd0;
    o_multi    = 1'b0;
    case (op_t'(i_op_code))
      OP_PUSH: begin o_movement = S_PUSH_ONCE; o_inc = 2'd1; end
      OP_DROP: begin o_movement = S_POP_ONCE; o_need = (RA_W+1)'(1); o_dec = 2'd1; end
      OP_DUP:  begin o_movement = S_PUSH_ONCE; o_need = (RA_W+1)'(1); o_inc = 2'd1; end
      OP_SWAP: begin o_rotate = 1'b1; o_need = (RA_W+1)'(2); end
      OP_OVER: begin o_movement = S_PUSH_ONCE; o_need = (RA_W+1)'(2); o_inc = 2'd1; end
      OP_PICK: begin
        o_movement = S_PUSH_ONCE; o_rot_addr = i_op_n; o_need = w_need_n; o_inc = 2'd1;
      end
      OP_ROLL: begin o_rotate = 1'b1; o_rot_addr = i_op_n; o_need = w_need_n; end
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NIP: begin
        o_movement = S_POP_ONCE; o_need = (RA_W+1)'(2); o_dec = 2'd1;
      end
      OP_DROP2: begin o_movement = S_POP_TWICE; o_need = (RA_W+1)'(2); o_dec = 2'd2; end
      // Checked as +2 up front; the top splits it into two +1 cycles.
      OP_DUP2: begin
        o_movement = S_PUSH_ONCE; o_need = (RA_W+1)'(2); o_inc = 2'd2; o_multi = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dstack_op_seq.sv
// Instruction sequencer in front of dstack: handshake, DUP2 split, depth/error tracking.
// Define DSTACK_DEPTH_CHECK_EN to enable the depth counter and underflow/overflow rejection.
module dstack_op_seq
  import dstack_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DEPTH_MAG = 7,
  parameter int DEPTH     = 65,
  localparam int RA_W     = DEPTH_MAG - 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 op_valid,
  output logic                 op_ready,
  input  logic [3:0]           op_code,
  input  logic [WIDTH-1:0]     op_imm,
  input  logic [RA_W-1:0]      op_n,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic                 err,
  output logic [1:0]           err_code,
  output logic [DEPTH_MAG-1:0] depth,
  output logic [1:0]           ds_movement,
  output logic [WIDTH-1:0]     ds_new_top,
  output logic                 ds_rotate,
  output logic [RA_W-1:0]      ds_rot_addr,
  input  logic [WIDTH-1:0]     ds_top,
  input  logic [WIDTH-1:0]     ds_second,
  input  logic [WIDTH-1:0]     ds_third,
  input  logic [WIDTH-1:0]     ds_rot_val
);

  seq_state_t          r_state, w_state_nxt;
  logic                r_out_valid;
  logic [WIDTH-1:0]    r_out_data;
  logic                w_issue, w_reject, w_go;
  logic [1:0]          w_mov, w_inc, w_dec;
  logic                w_rot, w_multi;
  logic [RA_W-1:0]     w_raddr;
  logic [RA_W:0]       w_need;
  logic [WIDTH-1:0]    w_nt;

  dstack_op_decode #(.RA_W(RA_W)) u_dec (
    .i_op_code (op_code),
    .i_op_n    (op_n),
    .o_movement(w_mov),
    .o_rotate  (w_rot),
    .o_rot_addr(w_raddr),
    .o_need    (w_need),
    .o_inc     (w_inc),
    .o_dec     (w_dec),
    .o_multi   (w_multi)
  );

  assign op_ready = (r_state == ST_IDLE);
  assign w_issue  = op_valid & op_ready;
  assign w_go     = w_issue & ~w_reject;

  always_comb begin
    w_nt = '0;
    case (op_t'(op_code))
      OP_PUSH:  w_nt = op_imm;
      OP_DROP:  w_nt = ds_second;
      OP_DUP, OP_NIP: w_nt = ds_top;
      OP_SWAP, OP_OVER, OP_PICK, OP_ROLL, OP_DUP2: w_nt = ds_rot_val;
      OP_ADD:   w_nt = ds_second + ds_top;
      OP_SUB:   w_nt = ds_second - ds_top;
      OP_AND:   w_nt = ds_second & ds_top;
      OP_OR:    w_nt = ds_second | ds_top;
      OP_XOR:   w_nt = ds_second ^ ds_top;
      OP_DROP2: w_nt = ds_third;
      default:  w_nt = '0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    ds_movement = S_NOTHING;
    ds_new_top  = '0;
    ds_rotate   = 1'b0;
    ds_rot_addr = '0;
    case (r_state)
      ST_IDLE: if (w_go) begin
        ds_movement = w_mov;
        ds_new_top  = w_nt;
        ds_rotate   = w_rot;
        ds_rot_addr = w_raddr;
        if (w_multi) w_state_nxt = ST_EXEC2;
      end
      // Second DUP2 push re-reads addr0, which now holds the old top.
      ST_EXEC2: begin
        ds_movement = S_PUSH_ONCE;
        ds_new_top  = ds_rot_val;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= w_go && (op_code == OP_DROP);
      if (w_go && (op_code == OP_DROP)) r_out_data <= ds_top;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

`ifdef DSTACK_DEPTH_CHECK_EN
  localparam logic [DEPTH_MAG:0] CAP = DEPTH_MAG'(DEPTH);

  logic [DEPTH_MAG-1:0] r_depth;
  logic                 r_err;
  logic [1:0]           r_err_code;
  logic                 w_uflow, w_oflow;

  assign w_uflow  = r_depth < w_need;
  assign w_oflow  = ({1'b0, r_depth} + (DEPTH_MAG+1)'(w_inc)) > CAP;
  assign w_reject = w_uflow | w_oflow;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_depth    <= '0;
      r_err      <= 1'b0;
      r_err_code <= 2'b00;
    end else begin
      r_err <= w_issue & w_reject;
      if (w_issue & w_reject) r_err_code <= w_uflow ? ERR_UNDERFLOW : ERR_OVERFLOW;
      if (r_state == ST_EXEC2)
        r_depth <= r_depth + DEPTH_MAG'(1);
      else if (w_go)
        r_depth <= r_depth + (w_multi ? DEPTH_MAG'(1) : DEPTH_MAG'(w_inc)) - DEPTH_MAG'(w_dec);
    end
  end

  assign depth    = r_depth;
  assign err      = r_err;
  assign err_code = r_err_code;
`else
  logic w_unused_chk;
  assign w_unused_chk = ^{w_need, w_inc, w_dec, DEPTH[0]};
  assign w_reject     = 1'b0;
  assign depth        = '0;
  assign err          = 1'b0;
  assign err_code     = 2'b00;
`endif

endmodule

// File: tb/tb_dstack_op_seq.sv
// Self-checking bench: dstack_op_seq driving a small behavioural dstack model.
module tb_dstack_op_seq;
  import dstack_pkg::*;

  localparam int W = 32;
  localparam int DEPTH = 65;

  logic          clk = 1'b0, reset = 1'b0;
  logic          op_valid = 1'b0, op_ready;
  logic [3:0]    op_code = 4'h0;
  logic [W-1:0]  op_imm = '0;
  logic [5:0]    op_n = '0;
  logic          out_valid, err, ds_rotate;
  logic [W-1:0]  out_data, ds_new_top, ds_top, ds_second, ds_third, ds_rot_val;
  logic [1:0]    err_code, ds_movement;
  logic [6:0]    depth;
  logic [5:0]    ds_rot_addr;

  int n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  dstack_op_seq #(.WIDTH(W), .DEPTH_MAG(7), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .op_imm(op_imm), .op_n(op_n),
    .out_valid(out_valid), .out_data(out_data), .err(err), .err_code(err_code),
    .depth(depth), .ds_movement(ds_movement), .ds_new_top(ds_new_top),
    .ds_rotate(ds_rotate), .ds_rot_addr(ds_rot_addr),
    .ds_top(ds_top), .ds_second(ds_second), .ds_third(ds_third), .ds_rot_val(ds_rot_val)
  );

  // Behavioural dstack: mem[sp-1] is top; rot_addr k addresses entry k+1 below top.
  logic [W-1:0] mem [0:127];
  int  sp;
  bit  m_ovf;
  int  m_ridx;
  assign m_ridx     = sp - 2 - int'(ds_rot_addr);
  assign ds_top     = (sp >= 1) ? mem[7'(sp-1)] : '0;
  assign ds_second  = (sp >= 2) ? mem[7'(sp-2)] : '0;
  assign ds_third   = (sp >= 3) ? mem[7'(sp-3)] : '0;
  assign ds_rot_val = (m_ridx >= 0) ? mem[7'(m_ridx)] : '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      sp <= 0; m_ovf <= 1'b0;
    end else begin
      case (ds_movement)
        2'b01: if (sp >= DEPTH) m_ovf <= 1'b1;
               else begin mem[7'(sp)] <= ds_new_top; sp <= sp + 1; end
        2'b10: if (sp >= 1) begin
                 if (sp >= 2) mem[7'(sp-2)] <= ds_new_top;
                 sp <= sp - 1;
               end
        2'b11: if (sp >= 2) begin
                 if (sp >= 3) mem[7'(sp-3)] <= ds_new_top;
                 sp <= sp - 2;
               end
        default: if (ds_rotate && sp >= int'(ds_rot_addr) + 2) begin
                   mem[7'(sp-1)] <= ds_new_top;
                   mem[7'(sp-2)] <= mem[7'(sp-1)];
                   for (int k = 1; k <= int'(ds_rot_addr); k++)
                     mem[7'(sp-2-k)] <= mem[7'(sp-1-k)];
                 end
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] edep(input int d);
`ifdef DSTACK_DEPTH_CHECK_EN
    return 32'(d);
`else
    return 32'(d - d);
`endif
  endfunction

  task automatic do_reset();
    op_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic issue(input logic [3:0] c, input logic [31:0] imm, input logic [5:0] n);
    op_valid = 1'b1; op_code = c; op_imm = imm; op_n = n;
    @(posedge clk); #1;
    op_valid = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  code;
    logic [31:0] imm;
    logic [5:0]  n;
    logic [1:0]  mov;
    logic [31:0] top;
    logic [31:0] sec;
    int          dep;
  } vec_t;
  vec_t vq[$];

  task automatic add(input logic [3:0] c, input logic [31:0] imm, input logic [5:0] n,
                     input logic [1:0] mov, input logic [31:0] t, input logic [31:0] s, input int d);
    vec_t v;
    v.code = c; v.imm = imm; v.n = n; v.mov = mov; v.top = t; v.sec = s; v.dep = d;
    vq.push_back(v);
  endtask

  initial begin
    add(OP_PUSH, 7, 0, 2'b01, 7, 0, 1);
    add(OP_PUSH, 5, 0, 2'b01, 5, 7, 2);
    add(OP_SUB,  0, 0, 2'b10, 2, 0, 1);
    add(OP_PUSH, 3, 0, 2'b01, 3, 2, 2);
    add(OP_ADD,  0, 0, 2'b10, 5, 0, 1);
    add(OP_PUSH, 6, 0, 2'b01, 6, 5, 2);
    add(OP_AND,  0, 0, 2'b10, 4, 0, 1);
    add(OP_PUSH, 3, 0, 2'b01, 3, 4, 2);
    add(OP_OR,   0, 0, 2'b10, 7, 0, 1);
    add(OP_PUSH, 5, 0, 2'b01, 5, 7, 2);
    add(OP_XOR,  0, 0, 2'b10, 2, 0, 1);
    add(OP_PUSH, 9, 0, 2'b01, 9, 2, 2);
    add(OP_DUP,  0, 0, 2'b01, 9, 9, 3);
    add(OP_PUSH, 1, 0, 2'b01, 1, 9, 4);
    add(OP_SWAP, 0, 0, 2'b00, 9, 1, 4);
    add(OP_OVER, 0, 0, 2'b01, 1, 9, 5);
    add(OP_PICK, 0, 2, 2'b01, 9, 1, 6);
    add(OP_NIP,  0, 0, 2'b10, 9, 9, 5);
    add(OP_DROP2,0, 0, 2'b11, 1, 9, 3);
    add(OP_NOP,  0, 0, 2'b00, 1, 9, 3);
    add(OP_PUSH, 3, 0, 2'b01, 3, 1, 4);
    add(OP_SUB,  0, 0, 2'b10, 32'hFFFF_FFFE, 9, 3);
    add(OP_DROP, 0, 0, 2'b10, 9, 2, 2);

    do_reset();
    chk("rst op_ready", 32'(op_ready), 1);
    chk("rst out_valid", 32'(out_valid), 0);
    chk("rst out_data", out_data, 0);
    chk("rst err", 32'(err), 0);
    chk("rst err_code", 32'(err_code), 0);
    chk("rst depth", 32'(depth), 0);
    chk("rst ds_movement", 32'(ds_movement), 0);

    foreach (vq[i]) begin
      op_valid = 1'b1; op_code = vq[i].code; op_imm = vq[i].imm; op_n = vq[i].n;
      #1;
      chk($sformatf("vec%0d movement", i), 32'(ds_movement), 32'(vq[i].mov));
      @(posedge clk); #1;
      op_valid = 1'b0;
      chk($sformatf("vec%0d top", i), ds_top, vq[i].top);
      chk($sformatf("vec%0d second", i), ds_second, vq[i].sec);
      chk($sformatf("vec%0d depth", i), 32'(depth), edep(vq[i].dep));
    end
    chk("vec DROP out_data", out_data, 32'hFFFF_FFFE);

    // ROLL n=1 on 10,20,30
    do_reset();
    issue(OP_PUSH, 10, 0); issue(OP_PUSH, 20, 0); issue(OP_PUSH, 30, 0);
    issue(OP_ROLL, 0, 1);
    chk("roll top", ds_top, 10);
    chk("roll second", ds_second, 30);
    chk("roll third", ds_third, 20);
    chk("roll depth", 32'(depth), edep(3));

    // DUP2 stalls one cycle; a held op waits for op_ready
    do_reset();
    issue(OP_PUSH, 1, 0); issue(OP_PUSH, 2, 0);
    op_valid = 1'b1; op_code = OP_DUP2;
    @(posedge clk); #1;
    op_code = OP_PUSH; op_imm = 77;
    chk("dup2 exec2 op_ready", 32'(op_ready), 0);
    chk("dup2 exec2 movement", 32'(ds_movement), 1);
    @(posedge clk); #1;
    chk("dup2 op_ready back", 32'(op_ready), 1);
    chk("dup2 top", ds_top, 2);
    chk("dup2 second", ds_second, 1);
    chk("dup2 third", ds_third, 2);
    chk("dup2 depth", 32'(depth), edep(4));
    @(posedge clk); #1;
    op_valid = 1'b0;
    chk("held push top", ds_top, 77);
    chk("held push depth", 32'(depth), edep(5));

    // DROP popped value
    do_reset();
    issue(OP_PUSH, 9, 0);
    issue(OP_DROP, 0, 0);
    chk("drop out_valid", 32'(out_valid), 1);
    chk("drop out_data", out_data, 9);
    @(posedge clk); #1;
    chk("drop out_valid pulse", 32'(out_valid), 0);

    // Reset while in EXEC2 abandons the second push
    do_reset();
    issue(OP_PUSH, 1, 0); issue(OP_PUSH, 2, 0);
    issue(OP_DUP2, 0, 0);
    reset = 1'b1; #1;
    chk("rst exec2 op_ready", 32'(op_ready), 1);
    chk("rst exec2 depth", 32'(depth), 0);
    chk("rst exec2 movement", 32'(ds_movement), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    issue(OP_PUSH, 4, 0);
    chk("post rst top", ds_top, 4);
    chk("post rst model depth", 32'(sp), 1);

`ifdef DSTACK_DEPTH_CHECK_EN
    do_reset();
    op_valid = 1'b1; op_code = OP_DROP;
    #1;
    chk("uflow ds idle", 32'(ds_movement), 0);
    chk("uflow op_ready", 32'(op_ready), 1);
    @(posedge clk); #1;
    op_valid = 1'b0;
    chk("uflow err", 32'(err), 1);
    chk("uflow err_code", 32'(err_code), 1);
    chk("uflow depth", 32'(depth), 0);
    chk("uflow model sp", 32'(sp), 0);
    @(posedge clk); #1;
    chk("uflow err pulse", 32'(err), 0);
    chk("uflow code held", 32'(err_code), 1);

    issue(OP_PUSH, 3, 0);
    issue(OP_PICK, 0, 0);
    chk("pick uflow err_code", 32'(err_code), 1);
    chk("pick uflow depth", 32'(depth), 1);

    do_reset();
    for (int i = 0; i < DEPTH; i++) issue(OP_PUSH, 0, 0);
    chk("full depth", 32'(depth), 65);
    chk("full no err", 32'(err), 0);
    issue(OP_PUSH, 1, 0);
    chk("oflow err", 32'(err), 1);
    chk("oflow err_code", 32'(err_code), 2);
    chk("oflow depth", 32'(depth), 65);
    chk("oflow model ovf", 32'(m_ovf), 0);
    chk("oflow top", ds_top, 0);
    issue(OP_DROP, 0, 0);
    chk("after oflow depth", 32'(depth), 64);
    chk("after oflow err", 32'(err), 0);
    chk("after oflow code held", 32'(err_code), 2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
